// File: rtl/booth_mult_r4_seq_pkg.sv
// booth_pkg: shared types and helpers for the radix-4 Booth multiplier family.
package booth_pkg;

   typedef enum logic [2:0] {ZERO, PLUS1, PLUS2, MINUS1, MINUS2} digit_op_e;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   // Unsigned operands need one extra digit to cover the zero-extended top bits.
   function automatic int booth_ndig(input int width, input int signed_mode);
      return (signed_mode != 0) ? width / 2 : width / 2 + 1;
   endfunction

   function automatic digit_op_e booth_decode(input logic [2:0] t);
      return (t == 3'b000 || t == 3'b111) ? ZERO :
             (t == 3'b011) ? PLUS2 :
             (t == 3'b100) ? MINUS2 :
             t[2] ? MINUS1 : PLUS1;
   endfunction

endpackage

// File: rtl/booth_mult_r4_seq_enc.sv
// booth_r4_enc: maps a Booth triplet and extended multiplicand to a partial product.
module booth_r4_enc
   import booth_pkg::*;
#(
   parameter int AW = 26
) (
   input  logic [2:0]    i_trip,
   input  logic [AW-1:0] i_x,
   output logic [AW-1:0] o_pp
);

   digit_op_e w_op;

   always_comb begin
      w_op = booth_decode(i_trip);
      o_pp = (w_op == PLUS1)  ? i_x :
             (w_op == PLUS2)  ? i_x << 1 :
             (w_op == MINUS1) ? -i_x :
             (w_op == MINUS2) ? -(i_x << 1) : '0;
   end

endmodule

// File: rtl/booth_mult_r4_seq.sv
// booth_mult_r4_seq: iterative radix-4 Booth multiplier, one digit per enabled cycle,
// valid/ready handshakes on operands and product.
module booth_mult_r4_seq
   import booth_pkg::*;
#(
   parameter int WIDTH  = 12,
   parameter int SIGNED = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     mult_1,
   input  logic [WIDTH-1:0]     mult_2,
   output logic [2*WIDTH-1:0]   result,
   output logic                 result_valid,
   input  logic                 result_ready,
   output logic                 busy
);

   localparam int AW   = 2 * WIDTH + 2;
   localparam int NDIG = booth_ndig(WIDTH, SIGNED);
   localparam int CW   = $clog2(NDIG) + 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   state_e             r_state;
   logic [WIDTH+2:0]   r_mp;
   logic [AW-1:0]      r_mc;
   logic [AW-1:0]      r_acc;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_result;
   logic               r_result_valid;
   logic               r_busy;
   logic [AW-1:0]      w_pp;
   logic [AW-1:0]      w_sum;
   logic               w_sx1;
   logic               w_sx2;

   assign w_sx1        = (SIGNED != 0) & mult_1[WIDTH-1];
   assign w_sx2        = (SIGNED != 0) & mult_2[WIDTH-1];
   assign w_sum        = r_acc + w_pp;
   assign in_ready     = (r_state == IDLE);
   assign result       = r_result;
   assign result_valid = r_result_valid;
   assign busy         = r_busy;

   // Multiplier shifts right and multiplicand left by one digit each step,
   // so the encoder always sees the current triplet at r_mp[2:0].
   booth_r4_enc #(.AW(AW)) u_enc (
      .i_trip (r_mp[2:0]),
      .i_x    (r_mc),
      .o_pp   (w_pp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_mp           <= '0;
         r_mc           <= '0;
         r_acc          <= '0;
         r_cnt          <= '0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: if (in_valid) begin
               r_mp    <= {{2{w_sx1}}, mult_1, 1'b0};
               r_mc    <= {{(WIDTH+2){w_sx2}}, mult_2};
               r_acc   <= '0;
               r_cnt   <= '0;
               r_busy  <= 1'b1;
               r_state <= CALC;
            end
            CALC: if (en) begin
               r_acc <= w_sum;
               r_mp  <= r_mp >> 2;
               r_mc  <= r_mc << 2;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_result       <= w_sum[2*WIDTH-1:0];
                  r_result_valid <= 1'b1;
                  r_state        <= DONE;
               end
            end
            DONE: if (result_ready) begin
               r_result_valid <= 1'b0;
               r_busy         <= 1'b0;
               r_state        <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
